threshold_table_loader: RTL
===========================

# threshold_table_loader

Sequencer that fills the comparator's per-CntC threshold RAM from a single fixed-point ratio. It computes entry[c] = min(floor(c·ratio / 2^FRAC_BITS), 2^CNT_WIDTH−1) for c = 0..VECTOR_WIDTH by repeated addition, with no multiplier or divider, and writes one entry per cycle over the comparator's BRAM write port. It sits between the wrapper's configuration register (threshold ratio, start) and the comparator. It also gates the datapath valid stream so that no comparisons run against a partially written table.

## Interface
- VECTOR_WIDTH, 920, fingerprint bit width; the table holds VECTOR_WIDTH+1 entries.
- CNT_WIDTH, $clog2(VECTOR_WIDTH), table entry and address width.
- RATIO_WIDTH, 16, width of the unsigned fixed-point ratio.
- FRAC_BITS, 8, fractional bits of the ratio.
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- i_Start  in  1  single-cycle load request.
- i_Ratio  in  RATIO_WIDTH  unsigned ratio; sampled only on an accepted i_Start.
- o_Busy  out  1  high while writing.
- o_Done  out  1  one-cycle pulse after the last write.
- o_Loaded  out  1  sticky flag: a complete table is present.
- o_DatapathEn  out  1  o_Loaded & ~o_Busy; the wrapper ANDs this into the comparator i_Valid.
- o_BRAM_Addr  out  CNT_WIDTH  write address.
- o_BRAM_Din  out  CNT_WIDTH  write data.
- o_BRAM_En  out  1  RAM enable: o_Busy | o_Loaded.
- o_BRAM_WrEn  out  1  write enable; high only in LOAD.
- o_Checksum  out  CNT_WIDTH  present only with the macro; see Configuration.

## Operation
- FSM states: IDLE → LOAD → DONE → IDLE.
- IDLE:
  - i_Start=1 is accepted.
  - Latch i_Ratio into r_Ratio. Clear accumulator r_Acc (width CNT_WIDTH+RATIO_WIDTH) and counter r_Idx. Clear o_Loaded.
  - Go to LOAD.
- LOAD, each cycle:
  - Drive o_BRAM_WrEn=1, o_BRAM_Addr=r_Idx, o_BRAM_Din=sat(r_Acc >> FRAC_BITS).
  - Update r_Acc += r_Ratio and r_Idx += 1.
  - When r_Idx == VECTOR_WIDTH is written, go to DONE.
- sat(x): returns x if x < 2^CNT_WIDTH, else 2^CNT_WIDTH−1 (all ones). The accumulator never wraps; its width covers VECTOR_WIDTH·(2^RATIO_WIDTH−1).
- DONE (one cycle):
  - o_Done=1, o_Loaded←1, WrEn=0.
  - Return to IDLE.
- i_Start in LOAD or DONE is ignored; it is neither queued nor used to re-latch the ratio.
- i_Start in IDLE with o_Loaded=1 is a reload. o_Loaded and o_DatapathEn drop in the cycle after acceptance.
- Ratio 0: all entries are 0. This is a legal load.
- Address and data outputs are registered. Address and data are don't-care when WrEn=0 but are held at their last value, which keeps toggling low.

## Timing
- Reset: every output is 0 (o_Busy, o_Done, o_Loaded, o_DatapathEn, o_BRAM_En, o_BRAM_WrEn, o_BRAM_Addr, o_BRAM_Din, o_Checksum). FSM goes to IDLE.
- With i_Start accepted at rising edge N:
  - o_Busy and o_BRAM_WrEn are high in cycles N+1 .. N+1+VECTOR_WIDTH.
  - Address k is presented in cycle N+1+k.
  - o_Done and o_Loaded rise in cycle N+2+VECTOR_WIDTH.
  - o_Busy falls in that same cycle.
- Load duration: VECTOR_WIDTH+1 write cycles plus 1 DONE cycle.
- o_DatapathEn rises with o_Loaded, so the first comparison is issued at or after N+2+VECTOR_WIDTH. This covers the RAM's one-cycle read latency.
- Reset during LOAD: the RAM is left partially written, o_Loaded=0, and there is no o_Done. A new i_Start is required.
- i_Start in the same cycle rstn=0: ignored.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - o_Checksum is the running XOR of every o_BRAM_Din written in LOAD.
  - It is cleared on start acceptance, is valid from o_Done, and is held until the next start.
  - The wrapper exposes it for software readback.
- LOADER_CHECKSUM_EN undefined: the port and the XOR register are absent.

## Test plan
- Identity table: VECTOR_WIDTH=920, ratio 0x0100 (1.0) → entry[c]=c for all c; o_Done in cycle N+922; 921 WrEn cycles.
- Saturation: ratio 0x0280 (2.5) → entry[7]=17 and entry[409]=1022; entry[410..920]=1023 (saturated).
- Busy start: i_Start again at N+50 with ratio 0x0100 during a 0x0280 load → ignored; the table matches 2.5 throughout; exactly one o_Done.
- Reset mid-load: rstn low at address 100 → all outputs 0; o_Loaded stays 0. A subsequent start with 0x0100 completes correctly.
- Reload gating: after a load, start a reload → o_DatapathEn low from N+1 to N+921 and high again at N+922.
- LOADER_CHECKSUM_EN build, ratio 0x0100, VECTOR_WIDTH=920 → o_Checksum = XOR of 0..920 = 920 (0x398) at o_Done.

Source files
------------

// File: rtl/threshold_table_loader.sv
// Fills the comparator threshold RAM with entry[c] = sat(floor(c * ratio / 2^FRAC_BITS)) using
// repeated addition. Optional running XOR of written data when LOADER_CHECKSUM_EN is defined.
module threshold_table_loader #(
  parameter int unsigned VECTOR_WIDTH = 920,
  parameter int unsigned CNT_WIDTH    = $clog2(VECTOR_WIDTH),
  parameter int unsigned RATIO_WIDTH  = 16,
  parameter int unsigned FRAC_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_Start,
  input  logic [RATIO_WIDTH-1:0] i_Ratio,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Loaded,
  output logic                   o_DatapathEn,
  output logic [CNT_WIDTH-1:0]   o_BRAM_Addr,
  output logic [CNT_WIDTH-1:0]   o_BRAM_Din,
  output logic                   o_BRAM_En,
`ifdef LOADER_CHECKSUM_EN
  output logic [CNT_WIDTH-1:0]   o_Checksum,
`endif
  output logic                   o_BRAM_WrEn
);

  localparam int unsigned AccWidth = CNT_WIDTH + RATIO_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LastAddr = CNT_WIDTH'(VECTOR_WIDTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                 state_q;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [AccWidth-1:0]    acc_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   loaded_q;
  logic                   wren_q;
  logic [CNT_WIDTH-1:0]   addr_q;
  logic [CNT_WIDTH-1:0]   din_q;
`ifdef LOADER_CHECKSUM_EN
  logic [CNT_WIDTH-1:0]   chk_q;
`endif

  function automatic logic [CNT_WIDTH-1:0] sat(input logic [AccWidth-1:0] acc);
    logic [AccWidth-1:0] s;
    s = acc >> FRAC_BITS;
    if (|s[AccWidth-1:CNT_WIDTH]) return '1;
    return s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      ratio_q  <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_Start) begin
            state_q  <= StLoad;
            ratio_q  <= i_Ratio;
            // Entry 0 is always 0; acc runs one entry ahead so data stays registered.
            acc_q    <= AccWidth'(i_Ratio);
            addr_q   <= '0;
            din_q    <= '0;
            busy_q   <= 1'b1;
            wren_q   <= 1'b1;
            loaded_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q    <= '0;
`endif
          end
        end
        StLoad: begin
`ifdef LOADER_CHECKSUM_EN
          chk_q <= chk_q ^ din_q;
`endif
          if (addr_q == LastAddr) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            wren_q   <= 1'b0;
            done_q   <= 1'b1;
            loaded_q <= 1'b1;
          end else begin
            addr_q <= addr_q + 1'b1;
            din_q  <= sat(acc_q);
            acc_q  <= acc_q + AccWidth'(ratio_q);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Loaded     = loaded_q;
  assign o_DatapathEn = loaded_q & ~busy_q;
  assign o_BRAM_En    = busy_q | loaded_q;
  assign o_BRAM_WrEn  = wren_q;
  assign o_BRAM_Addr  = addr_q;
  assign o_BRAM_Din   = din_q;
`ifdef LOADER_CHECKSUM_EN
  assign o_Checksum   = chk_q;
`endif

endmodule
